// File: rtl/zap_mult_pkg.sv
// Shared multiply/ALU definitions for the zap core.
// Holds ALU opcode constants and the iterative multiplier FSM encoding.
package zap_mult_pkg;

  localparam logic [3:0] ALU_MUL   = 4'h0;
  localparam logic [3:0] ALU_MLA   = 4'h1;
  localparam logic [3:0] ALU_UMULL = 4'h4;
  localparam logic [3:0] ALU_UMLAL = 4'h5;
  localparam logic [3:0] ALU_SMULL = 4'h6;
  localparam logic [3:0] ALU_SMLAL = 4'h7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ACC  = 2'd2
  } mult_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zap_multiply_iter_if.sv
// Request/result bundle between the issue logic and the iterative multiplier.
// Control inputs, operands and the result strobe travel together.
interface zap_multiply_iter_if #(
  parameter int DATA_W = 32
);
  logic                  i_clear_from_writeback;
  logic                  i_clear_from_alu;
  logic                  i_data_stall;
  logic                  i_start;
  logic                  i_signed;
  logic                  i_acc;
  logic                  i_hi;
  logic [DATA_W-1:0]     i_rm;
  logic [DATA_W-1:0]     i_rs;
  logic [DATA_W-1:0]     i_rh;
  logic [DATA_W-1:0]     i_rn;
  logic                  o_busy;
  logic                  o_done;
  logic [DATA_W-1:0]     o_rd;
  logic [2*DATA_W-1:0]   o_rd_full;
  logic                  o_nozero;

  modport master (
    output i_clear_from_writeback, i_clear_from_alu,
    output i_data_stall, i_start,
    output i_signed, i_acc, i_hi,
    output i_rm, i_rs, i_rh, i_rn,
    input  o_busy, o_done, o_rd,
    input  o_rd_full, o_nozero
  );

  modport slave (
    input  i_clear_from_writeback, i_clear_from_alu,
    input  i_data_stall, i_start,
    input  i_signed, i_acc, i_hi,
    input  i_rm, i_rs, i_rh, i_rn,
    output o_busy, o_done, o_rd,
    output o_rd_full, o_nozero
  );
endinterface

// File: rtl/zap_mult_slice.sv
// Combinational signed slice multiplier used by the iterative multiplier.
// Operands carry one extra bit so unsigned slices stay positive.
module zap_mult_slice #(
  parameter int SLICE_W = 16
) (
  input  logic signed [SLICE_W:0]     a,
  input  logic signed [SLICE_W:0]     b,
  output logic signed [2*SLICE_W+1:0] p
);
  localparam int PW = 2 * SLICE_W + 2;

  assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/zap_multiply_iter.sv
// Iterative slice-by-slice multiplier with accumulate and early exit.
// One partial product per cycle; result registered in the ACC state.
module zap_multiply_iter
  import zap_mult_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input logic i_clk,
  input logic i_reset,
  zap_multiply_iter_if.slave bus
);
  localparam int N     = DATA_W / SLICE_W;
  localparam int IDX_W = idx_w(N);
  localparam int SP    = SLICE_W + 1;
  localparam int FW    = 2 * DATA_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  mult_state_t            state;
  logic [DATA_W-1:0]      rm_q;
  logic [DATA_W-1:0]      rs_q;
  logic                   sgn_q;
  logic                   hi_q;
  logic [FW-1:0]          acch_q;
  logic [FW-1:0]          accum;
  logic [IDX_W-1:0]       i_idx;
  logic [IDX_W-1:0]       j_idx;
  logic [SLICE_W-1:0]     a_raw;
  logic [SLICE_W-1:0]     b_raw;
  logic signed [SP-1:0]   a_sl;
  logic signed [SP-1:0]   b_sl;
  logic signed [2*SP-1:0] prod;
  logic signed [FW-1:0]   prod_ext;
  logic [FW-1:0]          pp;
  logic [FW-1:0]          sum_full;
  logic [DATA_W-1:0]      rs_rest;
  logic                   last_i;
  logic                   last_j;
  logic                   accept;
  logic                   done_q;
  logic                   nz_q;
  logic [DATA_W-1:0]      rd_q;
  logic [FW-1:0]          full_q;

  assign last_i = (i_idx == LAST);
  assign last_j = (j_idx == LAST);
  assign a_raw  = SLICE_W'(rm_q >> (int'(i_idx) * SLICE_W));
  assign b_raw  = SLICE_W'(rs_q >> (int'(j_idx) * SLICE_W));

  // Only the top slice carries the operand sign.
  assign a_sl = {sgn_q & last_i & a_raw[SLICE_W-1], a_raw};
  assign b_sl = {sgn_q & last_j & b_raw[SLICE_W-1], b_raw};

  zap_mult_slice #(
    .SLICE_W(SLICE_W)
  ) u_slice (
    .a(a_sl),
    .b(b_sl),
    .p(prod)
  );

  assign prod_ext = FW'(prod);
  assign pp       = prod_ext << ((int'(i_idx) + int'(j_idx)) * SLICE_W);
  assign rs_rest  = rs_q >> ((int'(j_idx) + 1) * SLICE_W);
  assign sum_full = accum + acch_q;

  assign accept = (state == IDLE) & bus.i_start & ~i_reset
                & ~bus.i_clear_from_writeback
                & ~bus.i_data_stall
                & ~bus.i_clear_from_alu;

  assign bus.o_busy    = (state != IDLE) | accept;
  assign bus.o_done    = done_q;
  assign bus.o_rd      = rd_q;
  assign bus.o_rd_full = full_q;
  assign bus.o_nozero  = nz_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      rm_q   <= '0;
      rs_q   <= '0;
      sgn_q  <= 1'b0;
      hi_q   <= 1'b0;
      acch_q <= '0;
      accum  <= '0;
      i_idx  <= '0;
      j_idx  <= '0;
      done_q <= 1'b0;
      nz_q   <= 1'b0;
      rd_q   <= '0;
      full_q <= '0;
    end else if (bus.i_clear_from_writeback) begin
      state  <= IDLE;
      accum  <= '0;
      i_idx  <= '0;
      j_idx  <= '0;
      done_q <= 1'b0;
    end else if (bus.i_data_stall) begin
      done_q <= 1'b0;
    end else if (bus.i_clear_from_alu) begin
      state  <= IDLE;
      accum  <= '0;
      i_idx  <= '0;
      j_idx  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_start) begin
            rm_q   <= bus.i_rm;
            rs_q   <= bus.i_rs;
            sgn_q  <= bus.i_signed;
            hi_q   <= bus.i_hi;
            acch_q <= bus.i_acc ? {bus.i_rh, bus.i_rn} : '0;
            accum  <= '0;
            i_idx  <= '0;
            j_idx  <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          accum <= accum + pp;
          if (!last_i) begin
            i_idx <= i_idx + IDX_W'(1);
          end else begin
            i_idx <= '0;
            // Remaining multiplier slices all zero: nothing left to add.
            if (last_j || rs_rest == '0) begin
              j_idx <= '0;
              state <= ACC;
            end else begin
              j_idx <= j_idx + IDX_W'(1);
            end
          end
        end
        ACC: begin
          full_q <= sum_full;
          rd_q   <= hi_q ? sum_full[FW-1:DATA_W]
                         : sum_full[DATA_W-1:0];
          nz_q   <= hi_q & (|sum_full[DATA_W-1:0]);
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zap_multiply_iter.sv
// Self-checking bench for zap_multiply_iter: directed corner cases plus
// random operations compared against a plain-arithmetic reference model.
module tb_zap_multiply_iter;
  localparam int DW = 32;
  localparam int SW = 16;
  localparam int N  = DW / SW;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  zap_multiply_iter_if #(.DATA_W(DW)) bus ();

  zap_multiply_iter #(
    .DATA_W (DW),
    .SLICE_W(SW)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_full(
    input logic [31:0] rm, input logic [31:0] rs,
    input logic sgn, input logic acc,
    input logic [31:0] rh, input logic [31:0] rn);
    logic [63:0] a, b, r;
    a = sgn ? {{32{rm[31]}}, rm} : {32'h0, rm};
    b = sgn ? {{32{rs[31]}}, rs} : {32'h0, rs};
    r = a * b;
    if (acc) r = r + {rh, rn};
    return r;
  endfunction

  function automatic int model_steps(input logic [31:0] rs);
    int top = 0;
    for (int k = 0; k < N; k++)
      if (rs[k*SW +: SW] != '0) top = k;
    return N * (top + 1);
  endfunction

  task automatic drive_op(input logic [31:0] rm, input logic [31:0] rs,
                          input logic sgn, input logic acc, input logic hi,
                          input logic [31:0] rh, input logic [31:0] rn);
    bus.i_rm = rm; bus.i_rs = rs;
    bus.i_signed = sgn; bus.i_acc = acc; bus.i_hi = hi;
    bus.i_rh = rh; bus.i_rn = rn;
    bus.i_start = 1'b1;
  endtask

  task automatic scramble();
    bus.i_rm = $urandom; bus.i_rs = $urandom;
    bus.i_rh = $urandom; bus.i_rn = $urandom;
    bus.i_signed = 1'($urandom); bus.i_acc = 1'($urandom);
    bus.i_hi = 1'($urandom);
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] rm, input logic [31:0] rs,
                        input logic sgn, input logic acc, input logic hi,
                        input logic [31:0] rh, input logic [31:0] rn,
                        input int hold);
    logic [63:0] ef;
    logic [31:0] er;
    logic        enz;
    int          lat;
    ef  = model_full(rm, rs, sgn, acc, rh, rn);
    er  = hi ? ef[63:32] : ef[31:0];
    enz = hi && (ef[31:0] != 0);
    @(negedge clk);
    drive_op(rm, rs, sgn, acc, hi, rh, rn);
    #1 chk({tag, "_busy_accept"}, 64'(bus.o_busy), 64'd1);
    @(posedge clk);
    #1 scramble();
    if (hold == 0) bus.i_start = 1'b0;
    lat = 0;
    while (bus.o_done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
      if (lat >= hold) bus.i_start = 1'b0;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(model_steps(rs) + 1));
    chk({tag, "_full"}, bus.o_rd_full, ef);
    chk({tag, "_rd"}, 64'(bus.o_rd), 64'(er));
    chk({tag, "_nozero"}, 64'(bus.o_nozero), 64'(enz));
    @(posedge clk);
    #1 chk({tag, "_done_pulse"}, 64'(bus.o_done), 64'd0);
    chk({tag, "_hold"}, bus.o_rd_full, ef);
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1 if (bus.o_done === 1'b1) seen++;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rm, rs;
    int          pulses;
    bus.i_clear_from_writeback = 1'b0;
    bus.i_clear_from_alu = 1'b0;
    bus.i_data_stall = 1'b0;
    bus.i_start = 1'b0;
    scramble();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_done", 64'(bus.o_done), 64'd0);
    chk("rst_rd", 64'(bus.o_rd), 64'd0);
    chk("rst_full", bus.o_rd_full, 64'd0);
    chk("rst_nozero", 64'(bus.o_nozero), 64'd0);
    rst = 1'b0;

    run_op("ff_x_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    chk("ff_x_ff_const", bus.o_rd_full, 64'hFFFF_FFFE_0000_0001);
    run_op("sgn_min", 32'h8000_0000, 32'd2, 1, 0, 1, 0, 0, 0);
    chk("sgn_min_const", bus.o_rd_full, 64'hFFFF_FFFF_0000_0000);
    run_op("early", 32'h1234_5678, 32'd3, 0, 0, 0, 0, 0, 0);
    chk("early_const", bus.o_rd_full, 64'h0000_0000_369D_0368);
    run_op("acc_carry", 32'd2, 32'd3, 0, 1, 0, 32'd1, 32'hFFFF_FFFF, 0);
    chk("acc_carry_const", bus.o_rd_full, 64'h0000_0002_0000_0005);
    run_op("hi_nz", 32'd1, 32'd5, 0, 0, 1, 0, 0, 0);
    chk("hi_nz_rd", 64'(bus.o_rd), 64'd0);
    run_op("neg_neg", 32'hFFFF_FFFD, 32'hFFFF_FFF9, 1, 1, 1,
           32'h1, 32'h2, 0);
    run_op("start_held", 32'h10, 32'h0001_0000, 0, 0, 0, 0, 0, 3);

    // Stall in CALC, then clear from ALU.
    @(negedge clk);
    drive_op(32'd5, 32'h0002_0000, 0, 0, 0, 0, 0);
    @(posedge clk); #1 bus.i_start = 1'b0;
    @(posedge clk); #1 bus.i_data_stall = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1 if (bus.o_done === 1'b1) pulses++;
    end
    chk("stall_busy", 64'(bus.o_busy), 64'd1);
    bus.i_data_stall = 1'b0;
    bus.i_clear_from_alu = 1'b1;
    @(posedge clk); #1 bus.i_clear_from_alu = 1'b0;
    chk("clr_alu_busy", 64'(bus.o_busy), 64'd0);
    chk("clr_alu_done", 64'(pulses + int'(bus.o_done)), 64'd0);
    watch_no_done("clr_alu_nodone", 8);
    run_op("after_clr", 32'hDEAD_BEEF, 32'h0000_1234, 0, 0, 1, 0, 0, 0);

    // Writeback clear outranks stall.
    @(negedge clk);
    drive_op(32'd9, 32'h0003_0000, 0, 0, 0, 0, 0);
    @(posedge clk); #1 bus.i_start = 1'b0;
    @(posedge clk); #1;
    bus.i_data_stall = 1'b1;
    bus.i_clear_from_writeback = 1'b1;
    @(posedge clk); #1;
    bus.i_data_stall = 1'b0;
    bus.i_clear_from_writeback = 1'b0;
    chk("clr_wb_busy", 64'(bus.o_busy), 64'd0);
    watch_no_done("clr_wb_nodone", 8);

    // Stall outranks the ALU clear: operation resumes.
    @(negedge clk);
    drive_op(32'd3, 32'd4, 0, 0, 0, 0, 0);
    @(posedge clk); #1 bus.i_start = 1'b0;
    @(posedge clk); #1;
    bus.i_data_stall = 1'b1;
    bus.i_clear_from_alu = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.i_data_stall = 1'b0;
    bus.i_clear_from_alu = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1 if (bus.o_done === 1'b1) pulses++;
    end
    chk("stall_over_clr_done", 64'(pulses), 64'd1);
    chk("stall_over_clr_full", bus.o_rd_full, 64'd12);

    // Stall while in ACC: exactly one done after release.
    @(negedge clk);
    drive_op(32'd7, 32'd9, 0, 0, 0, 0, 0);
    @(posedge clk); #1 bus.i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.i_data_stall = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1 if (bus.o_done === 1'b1) pulses++;
    end
    chk("acc_stall_nodone", 64'(pulses), 64'd0);
    chk("acc_stall_hold", bus.o_rd_full, 64'd12);
    bus.i_data_stall = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1 if (bus.o_done === 1'b1) pulses++;
    end
    chk("acc_stall_once", 64'(pulses), 64'd1);
    chk("acc_stall_full", bus.o_rd_full, 64'd63);

    // Reset mid-operation.
    @(negedge clk);
    drive_op(32'h1111, 32'h0005_0000, 0, 0, 0, 0, 0);
    @(posedge clk); #1 bus.i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_full", bus.o_rd_full, 64'd0);
    chk("mid_rst_busy", 64'(bus.o_busy), 64'd0);
    watch_no_done("mid_rst_nodone", 8);

    for (int t = 0; t < 40; t++) begin
      rm = $urandom;
      rs = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 65535))
                                       : $urandom;
      run_op($sformatf("rnd%0d", t), rm, rs, 1'($urandom), 1'($urandom),
             1'($urandom), $urandom, $urandom, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zap_multiply_iter.md
ZAP_MULTIPLY_ITER -- requirements
Module: zap_multiply_iter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width in bits.
REQ-002 SHALL have parameter SLICE_W, default 16, multiplier slice width; DATA_W SHALL be an integer multiple of SLICE_W.
REQ-003 SHALL have ports: i_clk  in  1  sole clock; i_reset  in  1  reset.
REQ-004 Reset SHALL be synchronous and active-high on i_reset; i_clk is the only clock.
REQ-005 Port i_clear_from_writeback  in  1  abort current operation.
REQ-006 Port i_clear_from_alu  in  1  abort current operation (lower priority).
REQ-007 Port i_data_stall  in  1  freeze all state.
REQ-008 Port i_start  in  1  request a multiply.
REQ-009 Ports i_signed, i_acc, i_hi  in  1 each: signed operands; add accumulator; return high half on o_rd.
REQ-010 Ports i_rm, i_rs  in  DATA_W  multiplicand, multiplier; i_rh, i_rn  in  DATA_W  accumulator high and low words.
REQ-011 Ports o_busy  out  1; o_done  out  1  one-cycle result strobe; o_rd  out  DATA_W; o_rd_full  out  2*DATA_W; o_nozero  out  1.

Function
REQ-012 Let N = DATA_W/SLICE_W; FSM SHALL have states IDLE, CALC, ACC.
REQ-013 In IDLE with i_start=1 the block SHALL latch i_rm, i_rs, i_signed, i_acc, i_hi, {i_rh,i_rn} (zeroed if i_acc=0), clear the 2*DATA_W accumulator, reset indices, go to CALC.
REQ-014 o_busy SHALL be 1 in CALC and ACC and also in the IDLE cycle accepting i_start; 0 otherwise.
REQ-015 i_start SHALL be ignored outside IDLE.
REQ-016 CALC SHALL process one partial product per cycle, outer index j over rs slices, inner index i over rm slices, both 0..N-1.
REQ-017 Each step SHALL multiply two (SLICE_W+1)-bit signed slices: top slice (index N-1) sign-extended when latched i_signed=1, all other slices zero-extended; product shifted left by (i+j)*SLICE_W, sign-extended to 2*DATA_W, added modulo 2^(2*DATA_W).
REQ-018 Early termination: after the last i of slice j, if all rs slices j+1..N-1 are zero, CALC SHALL exit to ACC immediately.
REQ-019 Without early termination CALC SHALL last N*N cycles; with DATA_W=32, SLICE_W=16 that is 4.
REQ-020 ACC SHALL add the latched {rh,rn}, register o_rd_full, set o_rd = i_hi ? upper half : lower half, pulse o_done for exactly one cycle, and return to IDLE.
REQ-021 o_nozero SHALL be 1 with o_done when latched i_hi=1 and lower half of o_rd_full is nonzero; 0 otherwise.
REQ-022 o_rd, o_rd_full, o_nozero SHALL hold their last values until the next ACC.
REQ-023 Latency: o_done SHALL assert in the (steps+1)th cycle after the accepting edge, steps = partial products executed.
REQ-024 Priority SHALL be: i_reset > i_clear_from_writeback > i_data_stall > i_clear_from_alu > normal operation.
REQ-025 Either clear SHALL return the FSM to IDLE, zero the accumulator and indices, and suppress o_done; output result registers unchanged.
REQ-026 i_data_stall SHALL hold state, indices, accumulator and result registers; o_done SHALL be 0 while stalled and appear once on the first unstalled ACC cycle.

Reset
REQ-027 On i_reset: state IDLE, accumulator, indices, o_rd, o_rd_full zero; o_busy=0, o_done=0, o_nozero=0.
REQ-028 Reset mid-operation SHALL discard the operation with no o_done.

Structure
REQ-029 State encodings SHALL reside in the shared package zap_mult_pkg alongside the existing ALU opcode constants.
REQ-030 The slice multiplier SHALL be a sub-module zap_mult_slice, parametrised by SLICE_W, purely combinational, (SLICE_W+1)x(SLICE_W+1) signed -> 2*(SLICE_W+1) signed.

Verification (DATA_W=32, SLICE_W=16)
REQ-031 Unsigned rm=rs=0xFFFFFFFF, i_acc=0 -> o_rd_full=0xFFFFFFFE_00000001, o_done 5 cycles after accept.
REQ-032 Signed rm=0x80000000, rs=2, i_hi=1 -> o_rd_full=0xFFFFFFFF_00000000, o_rd=0xFFFFFFFF, o_nozero=0.
REQ-033 Unsigned rm=0x12345678, rs=3 -> early termination, o_rd_full=0x00000000_369D0368, o_done 3 cycles after accept.
REQ-034 rm=2, rs=3, i_acc=1, rh=0x1, rn=0xFFFFFFFF -> o_rd_full=0x00000002_00000005 (carry into high word).
REQ-035 rm=1, rs=5, i_hi=1 -> o_rd=0, o_nozero=1.
REQ-036 Stall 3 cycles in CALC then i_clear_from_alu -> no o_done, o_busy=0 next cycle, next i_start computes correctly.
